// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and helpers for the three-floor car controller.
//   NUM_FLOORS    - number of served floors
//   floor_t       - floor index (0..2)
//   car_state_t   - car controller state
//   req_above/below - is any request pending beyond a given floor
//   floor_onehot  - floor index to one-hot floor vector
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } car_state_t;

  function automatic logic req_above(input logic [NUM_FLOORS-1:0] req, input floor_t f);
    case (f)
      2'd0:    req_above = req[1] | req[2];
      2'd1:    req_above = req[2];
      default: req_above = 1'b0;
    endcase
  endfunction

  function automatic logic req_below(input logic [NUM_FLOORS-1:0] req, input floor_t f);
    case (f)
      2'd2:    req_below = req[1] | req[0];
      2'd1:    req_below = req[0];
      default: req_below = 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
    floor_onehot = 3'b001 << f;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync: brings one asynchronous push-button into the clk_50 domain and
// produces a single-cycle pulse on each press.
//   clk_50 - system clock
//   rst    - asynchronous active-high reset
//   btn_i  - raw button level
//   rise_o - one-cycle pulse per rising edge of the synchronised button
module btn_sync (
  input  logic clk_50,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A held button leaves sync2_q == prev_q, so only the press itself pulses.
  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: three-floor elevator car controller.
//   clk_50     - system clock
//   rst        - asynchronous active-high reset
//   tick       - slow step clock from the divider (rising edge used)
//   btn[2:0]   - raw floor-request buttons, bit i = floor i
//   led1..led3 - one-hot current floor indicators (floor 0..2)
//   door_open  - door is open
//   moving     - car is travelling
//   dir_up     - last/current travel direction is up
//   pending    - latched, unserved requests
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = 2
) (
  input  logic                  clk_50,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] btn,
  output logic                  led1,
  output logic                  led2,
  output logic                  led3,
  output logic                  door_open,
  output logic                  moving,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam logic [1:0] DOOR_LAST = 2'(DOOR_TICKS);

  logic [NUM_FLOORS-1:0] btn_rise;

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
    btn_sync u_btn_sync (
      .clk_50 (clk_50),
      .rst    (rst),
      .btn_i  (btn[gi]),
      .rise_o (btn_rise[gi])
    );
  end

  car_state_t            state_q, state_d;
  floor_t                floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [1:0]            door_cnt_q, door_cnt_d;
  logic [NUM_FLOORS-1:0] leds_q;
  logic                  door_open_q;
  logic                  moving_q;
  logic                  tick_q;
  logic                  step_q;

  logic [NUM_FLOORS-1:0] pend_w;
  floor_t                floor_up;
  floor_t                floor_dn;
  logic [NUM_FLOORS-1:0] cur_oh;
  logic [NUM_FLOORS-1:0] up_oh;
  logic [NUM_FLOORS-1:0] dn_oh;

  // Requests seen this cycle count immediately, so a press at the floor
  // being served never shows up in pending.
  assign pend_w   = pending_q | btn_rise;
  assign floor_up = floor_q + 2'd1;
  assign floor_dn = floor_q - 2'd1;
  assign cur_oh   = floor_onehot(floor_q);
  assign up_oh    = floor_onehot(floor_up);
  assign dn_oh    = floor_onehot(floor_dn);

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    pending_d  = pend_w;
    door_cnt_d = door_cnt_q;
    case (state_q)
      IDLE: begin
        if (|(pend_w & cur_oh)) begin
          pending_d  = pend_w & ~cur_oh;
          state_d    = DOOR_OPEN;
          door_cnt_d = 2'd0;
        end else if (dir_up_q && req_above(pend_w, floor_q)) begin
          state_d = MOVE_UP;
        end else if (!dir_up_q && req_below(pend_w, floor_q)) begin
          state_d = MOVE_DOWN;
        end else if (req_above(pend_w, floor_q)) begin
          dir_up_d = 1'b1;
          state_d  = MOVE_UP;
        end else if (req_below(pend_w, floor_q)) begin
          dir_up_d = 1'b0;
          state_d  = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        // No target above also covers the top-floor bound.
        if (!req_above(pend_w, floor_q)) begin
          state_d = IDLE;
        end else if (step_q) begin
          floor_d = floor_up;
          if (|(pend_w & up_oh)) begin
            pending_d  = pend_w & ~up_oh;
            state_d    = DOOR_OPEN;
            door_cnt_d = 2'd0;
          end else if (!req_above(pend_w, floor_up)) begin
            state_d = IDLE;
          end
        end
      end
      MOVE_DOWN: begin
        if (!req_below(pend_w, floor_q)) begin
          state_d = IDLE;
        end else if (step_q) begin
          floor_d = floor_dn;
          if (|(pend_w & dn_oh)) begin
            pending_d  = pend_w & ~dn_oh;
            state_d    = DOOR_OPEN;
            door_cnt_d = 2'd0;
          end else if (!req_below(pend_w, floor_dn)) begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        pending_d = pend_w & ~cur_oh;
        // A fresh press at this floor holds the door for a full period again.
        if (|(btn_rise & cur_oh)) begin
          door_cnt_d = 2'd0;
        end else if (step_q) begin
          if (door_cnt_q + 2'd1 == DOOR_LAST) begin
            state_d    = IDLE;
            door_cnt_d = 2'd0;
          end else begin
            door_cnt_d = door_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      floor_q     <= 2'd0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      door_cnt_q  <= 2'd0;
      leds_q      <= 3'b001;
      door_open_q <= 1'b0;
      moving_q    <= 1'b0;
      tick_q      <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      tick_q      <= tick;
      step_q      <= tick & ~tick_q;
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      door_cnt_q  <= door_cnt_d;
      leds_q      <= floor_onehot(floor_d);
      door_open_q <= (state_d == DOOR_OPEN);
      moving_q    <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
    end
  end

  assign led1      = leds_q[0];
  assign led2      = leds_q[1];
  assign led3      = leds_q[2];
  assign door_open = door_open_q;
  assign moving    = moving_q;
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
module tb_elevator_car_ctrl;

  logic       clk_50 = 1'b0;
  logic       rst    = 1'b1;
  logic       tick   = 1'b0;
  logic [2:0] btn    = 3'b000;
  logic       led1, led2, led3;
  logic       door_open, moving, dir_up;
  logic [2:0] pending;

  int checks   = 0;
  int failures = 0;

  elevator_car_ctrl #(.DOOR_TICKS(2)) dut (
    .clk_50    (clk_50),
    .rst       (rst),
    .tick      (tick),
    .btn       (btn),
    .led1      (led1),
    .led2      (led2),
    .led3      (led3),
    .door_open (door_open),
    .moving    (moving),
    .dir_up    (dir_up),
    .pending   (pending)
  );

  always #5 clk_50 = ~clk_50;

  function automatic int floor_of(input logic [2:0] l);
    case (l)
      3'b001:  floor_of = 0;
      3'b010:  floor_of = 1;
      3'b100:  floor_of = 2;
      default: floor_of = 9;
    endcase
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic apply_reset;
    @(negedge clk_50);
    rst  = 1'b1;
    btn  = 3'b000;
    tick = 1'b0;
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);
  endtask

  // One divider tick: high 2 cycles, then low long enough to re-arm.
  task automatic tick_step;
    tick = 1'b1;
    repeat (2) @(negedge clk_50);
    tick = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic press_btn(input logic [2:0] mask);
    btn = mask;
    repeat (4) @(negedge clk_50);
    btn = 3'b000;
    repeat (3) @(negedge clk_50);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk_50);
    checks++;
    if ({led3, led2, led1} !== 3'b001) begin
      failures++;
      $display("FAIL reset_led_during: got=%b want=001", {led3, led2, led1});
    end
    @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);
    checks++;
    if ({led3, led2, led1, pending, door_open, moving, dir_up} !== 9'b001_000_001) begin
      failures++;
      $display("FAIL reset_state: got leds=%b pend=%b door=%b mov=%b dir=%b want leds=001 pend=000 door=0 mov=0 dir=1",
               {led3, led2, led1}, pending, door_open, moving, dir_up);
    end
    $display("txn reset leds=%b pend=%b", {led3, led2, led1}, pending);
  endtask

  task automatic test_current_floor;
    logic seen;
    seen = 1'b0;
    apply_reset();
    btn = 3'b001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50);
      if (pending[0]) seen = 1'b1;
      if (i == 3) btn = 3'b000;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL curfloor_pending: got pending[0] high want never");
    end
    checks++;
    if ({door_open, led3, led2, led1} !== 4'b1_001) begin
      failures++;
      $display("FAIL curfloor_door: got door=%b leds=%b want door=1 leds=001", door_open, {led3, led2, led1});
    end
    tick_step();
    press_btn(3'b001);               // restarts the door counter
    tick_step();
    checks++;
    if (door_open !== 1'b1) begin
      failures++;
      $display("FAIL door_restart_hold: got door=%b want 1", door_open);
    end
    tick_step();
    checks++;
    if (door_open !== 1'b0 || moving !== 1'b0) begin
      failures++;
      $display("FAIL door_restart_close: got door=%b mov=%b want 0 0", door_open, moving);
    end
    $display("txn current_floor door=%b", door_open);
  endtask

  task automatic test_move_up;
    apply_reset();
    btn = 3'b100;
    repeat (2) @(negedge clk_50);
    checks++;
    if (pending !== 3'b000) begin
      failures++;
      $display("FAIL pend_early: got=%b want 000 after 2 cycles", pending);
    end
    @(negedge clk_50);
    checks++;
    if (pending !== 3'b100 || moving !== 1'b1 || dir_up !== 1'b1) begin
      failures++;
      $display("FAIL pend_3cyc: got pend=%b mov=%b dir=%b want 100 1 1", pending, moving, dir_up);
    end
    repeat (7) @(negedge clk_50);
    btn = 3'b000;
    repeat (3) @(negedge clk_50);
    tick = 1'b1;
    @(negedge clk_50);
    checks++;
    if ({led3, led2, led1} !== 3'b001) begin
      failures++;
      $display("FAIL led_latency_1: got=%b want 001 one edge after tick", {led3, led2, led1});
    end
    @(negedge clk_50);
    checks++;
    if ({led3, led2, led1} !== 3'b010) begin
      failures++;
      $display("FAIL led_latency_2: got=%b want 010 two edges after tick", {led3, led2, led1});
    end
    tick = 1'b0;
    @(negedge clk_50);
    tick_step();
    checks++;
    if ({led3, led2, led1, door_open, pending, moving} !== 8'b100_1_000_0) begin
      failures++;
      $display("FAIL arrive_f2: got leds=%b door=%b pend=%b mov=%b want 100 1 000 0",
               {led3, led2, led1}, door_open, pending, moving);
    end
    tick_step();
    checks++;
    if (door_open !== 1'b1) begin
      failures++;
      $display("FAIL door_hold_f2: got door=%b want 1", door_open);
    end
    tick_step();
    checks++;
    if (door_open !== 1'b0 || moving !== 1'b0) begin
      failures++;
      $display("FAIL door_close_f2: got door=%b mov=%b want 0 0", door_open, moving);
    end
    $display("txn move_up leds=%b", {led3, led2, led1});
  endtask

  task automatic test_stop_reverse;
    apply_reset();
    press_btn(3'b110);
    press_btn(3'b001);
    checks++;
    if (pending !== 3'b111 || moving !== 1'b1) begin
      failures++;
      $display("FAIL rev_pending: got pend=%b mov=%b want 111 1", pending, moving);
    end
    tick_step();
    checks++;
    if ({led3, led2, led1, door_open, pending} !== 7'b010_1_101) begin
      failures++;
      $display("FAIL rev_stop_f1: got leds=%b door=%b pend=%b want 010 1 101", {led3, led2, led1}, door_open, pending);
    end
    tick_step();
    tick_step();
    tick_step();
    checks++;
    if ({led3, led2, led1, door_open, pending} !== 7'b100_1_001) begin
      failures++;
      $display("FAIL rev_stop_f2: got leds=%b door=%b pend=%b want 100 1 001", {led3, led2, led1}, door_open, pending);
    end
    tick_step();
    tick_step();
    checks++;
    if (dir_up !== 1'b0 || moving !== 1'b1) begin
      failures++;
      $display("FAIL rev_dir: got dir=%b mov=%b want 0 1", dir_up, moving);
    end
    tick_step();
    checks++;
    if ({led3, led2, led1, door_open, moving} !== 5'b010_0_1) begin
      failures++;
      $display("FAIL rev_pass_f1: got leds=%b door=%b mov=%b want 010 0 1", {led3, led2, led1}, door_open, moving);
    end
    tick_step();
    checks++;
    if ({led3, led2, led1, door_open, pending} !== 7'b001_1_000) begin
      failures++;
      $display("FAIL rev_stop_f0: got leds=%b door=%b pend=%b want 001 1 000", {led3, led2, led1}, door_open, pending);
    end
    tick_step();
    tick_step();
    checks++;
    if (door_open !== 1'b0 || moving !== 1'b0) begin
      failures++;
      $display("FAIL rev_idle: got door=%b mov=%b want 0 0", door_open, moving);
    end
    $display("txn stop_reverse leds=%b dir=%b", {led3, led2, led1}, dir_up);
  endtask

  task automatic test_held_tick;
    int changes;
    logic [2:0] prev;
    apply_reset();
    press_btn(3'b100);
    changes = 0;
    prev = {led3, led2, led1};
    tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50);
      if ({led3, led2, led1} != prev) changes++;
      prev = {led3, led2, led1};
    end
    tick = 1'b0;
    repeat (2) @(negedge clk_50);
    checks++;
    if (changes != 1 || {led3, led2, led1} !== 3'b010) begin
      failures++;
      $display("FAIL held_tick: got changes=%0d leds=%b want 1 010", changes, {led3, led2, led1});
    end
    $display("txn held_tick changes=%0d", changes);
  endtask

  task automatic test_reset_mid_move;
    checks++;
    if (pending !== 3'b100 || moving !== 1'b1) begin
      failures++;
      $display("FAIL midmove_pre: got pend=%b mov=%b want 100 1", pending, moving);
    end
    @(negedge clk_50);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({led3, led2, led1, pending, moving, door_open} !== 8'b001_000_0_0) begin
      failures++;
      $display("FAIL midmove_reset: got leds=%b pend=%b mov=%b door=%b want 001 000 0 0",
               {led3, led2, led1}, pending, moving, door_open);
    end
    @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);
    $display("txn reset_mid_move leds=%b", {led3, led2, led1});
  endtask

  // Random request sets against a collective-control (sweep) model:
  // serve the current floor, then everything in the preferred direction,
  // then everything behind.
  task automatic test_random_sweep;
    int m_floor;
    logic m_dir;
    m_floor = 0;
    m_dir   = 1'b1;
    for (int t = 0; t < 12; t++) begin
      logic [2:0] mask;
      int exp_code, got_code, n_exp, n_got, last_stop;
      logic has_up, has_dn, go_up, end_dir, prev_door, done;
      mask = 3'($urandom_range(1, 7));
      exp_code = 0;
      n_exp = 0;
      last_stop = m_floor;
      has_up = 1'b0;
      has_dn = 1'b0;
      for (int f = 0; f < 3; f++) begin
        if (mask[f] && f > m_floor) has_up = 1'b1;
        if (mask[f] && f < m_floor) has_dn = 1'b1;
      end
      go_up = m_dir ? (has_up || !has_dn) : (has_up && !has_dn);
      if (mask[m_floor]) begin
        exp_code = exp_code * 10 + m_floor + 1;
        n_exp++;
      end
      for (int ph = 0; ph < 2; ph++) begin
        logic up_phase;
        up_phase = (ph == 0) ? go_up : !go_up;
        if (up_phase) begin
          for (int f = m_floor + 1; f < 3; f++)
            if (mask[f]) begin exp_code = exp_code * 10 + f + 1; n_exp++; last_stop = f; end
        end else begin
          for (int f = m_floor - 1; f >= 0; f--)
            if (mask[f]) begin exp_code = exp_code * 10 + f + 1; n_exp++; last_stop = f; end
        end
      end
      if (go_up) end_dir = has_dn ? 1'b0 : (has_up ? 1'b1 : m_dir);
      else       end_dir = has_up ? 1'b1 : (has_dn ? 1'b0 : m_dir);

      press_btn(mask);
      got_code = 0;
      n_got = 0;
      prev_door = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 30 && !done; k++) begin
        if (door_open && !prev_door) begin
          got_code = got_code * 10 + floor_of({led3, led2, led1}) + 1;
          n_got++;
        end
        prev_door = door_open;
        if (n_got >= n_exp && !door_open && !moving) done = 1'b1;
        else tick_step();
      end
      $display("txn random %0d mask=%b from=%0d exp_stops=%0d got_stops=%0d", t, mask, m_floor, exp_code, got_code);
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL rand_timeout: txn %0d did not settle within 30 steps", t);
      end
      checks++;
      if (got_code != exp_code) begin
        failures++;
        $display("FAIL rand_stops: txn %0d got=%0d want=%0d", t, got_code, exp_code);
      end
      checks++;
      if (floor_of({led3, led2, led1}) != last_stop || dir_up !== end_dir || pending !== 3'b000) begin
        failures++;
        $display("FAIL rand_final: txn %0d got floor=%0d dir=%b pend=%b want floor=%0d dir=%b pend=000",
                 t, floor_of({led3, led2, led1}), dir_up, pending, last_stop, end_dir);
      end
      m_floor = last_stop;
      m_dir   = end_dir;
    end
  endtask

  initial begin
    test_reset();
    test_current_floor();
    test_move_up();
    test_stop_reverse();
    test_held_tick();
    test_reset_mid_move();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/elevator_car_ctrl.md
# elevator_car_ctrl

Car controller for the three-floor elevator. It latches floor-request buttons and moves the car one floor per rising edge of the slow `tick` from the frequency divider. It opens the door at each requested floor and drives the one-hot floor indicators `led1..led3`. The rising edges on those indicators are what restart the divider, so this block is the other end of the divider's `led*` / `clk` interface.

## Interface
Parameters:
- `DOOR_TICKS`, default 2: number of step events the door stays open (legal range 1..3).

Ports:
- `clk_50`, input, 1: system clock. Every flop in the block is on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `tick`, input, 1: step clock from the divider. It is generated in the `clk_50` domain. Only its rising edge is used.
- `btn`, input, 3: raw floor-request buttons. Bit *i* is floor *i*. Level-sensitive and asynchronous.
- `led1`, `led2`, `led3`, output, 1 each: one-hot current floor (floor 0, 1, 2).
- `door_open`, output, 1: door is open.
- `moving`, output, 1: state is MOVE_UP or MOVE_DOWN.
- `dir_up`, output, 1: last or current travel direction is up.
- `pending`, output, 3: latched, unserved requests.

## Operation
- Reset values: `led1`=1, `led2`=0, `led3`=0, `door_open`=0, `moving`=0, `dir_up`=1, `pending`=000, state IDLE, door counter 0.
- Buttons:
  - Each button goes through a 2-flop synchronizer and then a rising-edge detector.
  - A detected edge sets `pending[i]`.
  - Holding a button generates no further requests.
- Step event (`step`): `tick` is registered once; `step` = `tick & ~tick_q`. `step` is high for exactly one `clk_50` cycle per tick rising edge.
- States:
  - **IDLE**
    - `pending[cur]` set: clear it and go to DOOR_OPEN. Door counter loads 0.
    - Else if a request exists in the current direction: move that way.
    - Else if a request exists in the opposite direction: flip `dir_up` and move that way.
    - Else stay in IDLE.
  - **MOVE_UP / MOVE_DOWN**
    - On `step`: floor index moves ±1. The one-hot LEDs update in the same register write.
    - If the new floor is pending: clear its bit, go to DOOR_OPEN.
    - Else if further requests exist in the travel direction: stay in the same state.
    - Else: go to IDLE.
  - **DOOR_OPEN**
    - `door_open`=1.
    - Each `step` increments the door counter. When the counter reaches `DOOR_TICKS`, go to IDLE.
    - A request edge for the current floor keeps `pending[cur]`=0 and resets the counter to 0.
- Bounds:
  - The car never moves below floor 0 or above floor 2.
  - A direction request with no pending floor beyond the current floor is impossible by construction. If it ever occurs, the state returns to IDLE.
- Same-cycle events:
  - Arriving at floor *i* while a new edge for *i* is detected: the request counts as served and the bit stays 0.
  - A request edge for another floor while that floor's bit is being cleared cannot occur, since only the current floor is ever cleared.
- `rst` asserted mid-move or mid-door: every register returns to its reset value immediately. Pending requests are lost.

## Timing
- Button edge to `pending` bit set: 3 `clk_50` cycles (2 sync flops plus 1 edge flop).
- `tick` rising edge to LED change: the LED updates on the 2nd `clk_50` edge after `tick` goes high (edge register, then state register).
- IDLE to MOVE decision: 1 cycle. The first floor change happens on the next `step`, never in the same cycle as the decision.
- Door closes `DOOR_TICKS` steps after opening. The IDLE re-evaluation happens 1 cycle after the close.
- The LED one-hot invariant holds in every cycle, including during reset.

## Structure
- Package `elevator_pkg`:
  - `NUM_FLOORS` = 3.
  - Floor index type (2 bits).
  - State enum `car_state_t` with IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- Sub-module `btn_sync`: 2-flop synchronizer plus rising-edge pulse, with `clk_50` and `rst` ports. It is instantiated 3 times.
- Top level contains `tick` edge detection, the FSM, the pending register, the door counter and the LED decode.

## Test plan
- Reset check: apply `rst` for 3 cycles, then release. Expect `led1`=1, `pending`=000, `door_open`=0, `moving`=0, `dir_up`=1.
- Move up to floor 2: press `btn[2]` at floor 0 and hold it for 10 cycles. Expect:
  - `pending`=100 after 3 cycles;
  - MOVE_UP;
  - `led2` after the 1st `step`, `led3` after the 2nd;
  - `door_open`=1 and `pending`=000;
  - IDLE after 2 further steps.
- Request at current floor: press `btn[0]` while IDLE at floor 0. Expect DOOR_OPEN with no `led` change and `pending[0]` never observed high. A repeat press while the door is open restarts the 2-step counter.
- Stop on the way and reverse: at floor 0 press `btn[1]` and `btn[2]` together, then press `btn[0]` while moving. Expect:
  - a stop at floor 1 (door opens), then a stop at floor 2;
  - then `dir_up`=0 and travel down to floor 0, with a door cycle there.
- Held tick: hold `tick` high for 20 cycles while in MOVE_UP. Expect exactly one floor change.
- Reset mid-move: assert `rst` between floor 1 and floor 2 with `pending`=100. Expect immediate `led1`=1, `pending`=000, `moving`=0.
